// File: rtl/cardinal_pkg.sv
// Shared packet layout for the cardinal ring router: packet width, VC bit position
// and payload field (packets are indexed MSB-first, [0:PACKET_SIZE-1]).
package cardinal_pkg;
  localparam int PACKET_SIZE = 64;
  localparam int VC_BIT      = 0;
  localparam int PAYLOAD_LSB = 32;
  localparam int PAYLOAD_MSB = 63;

  typedef logic [0:PACKET_SIZE-1] packet_t;

  function automatic logic [31:0] payload_of(input packet_t pkt);
    return pkt[PAYLOAD_LSB:PAYLOAD_MSB];
  endfunction
endpackage

// File: rtl/cardinal_sync_fifo.sv
// Synchronous FIFO with a combinational head; full and empty are told apart by an
// extra wrap bit on each pointer.
module cardinal_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [0:WIDTH-1] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [0:WIDTH-1] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [0:WIDTH-1] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A push on a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/cardinal_pe_port.sv
// Local (PE) port of a cardinal ring router: NIC ingress into two per-VC holding
// registers drained to the fabric, and fabric egress to the NIC through a small FIFO.
module cardinal_pe_port import cardinal_pkg::*; #(
  parameter int PACKET_SIZE = cardinal_pkg::PACKET_SIZE,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   net_polarity,
  input  logic                   net_so,
  output logic                   net_ro,
  input  logic [0:PACKET_SIZE-1] net_do,
  output logic                   net_si,
  input  logic                   net_ri,
  output logic [0:PACKET_SIZE-1] net_di,
  output logic                   fab_tx_valid,
  input  logic                   fab_tx_ready,
  output logic [0:PACKET_SIZE-1] fab_tx_data,
  input  logic                   fab_rx_valid,
  output logic                   fab_rx_ready,
  input  logic [0:PACKET_SIZE-1] fab_rx_data,
  output logic                   proto_err,
  output logic [CNT_W-1:0]       rx_cnt,
  output logic [CNT_W-1:0]       tx_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic                   r_pol;
  logic [1:0]             r_vc_full;
  logic [0:PACKET_SIZE-1] r_vc_reg [2];
  logic                   r_proto_err;
  logic [CNT_W-1:0]       r_rx_cnt;
  logic [CNT_W-1:0]       r_tx_cnt;
  logic                   r_si;
  logic [0:PACKET_SIZE-1] r_di;

  logic                   w_ro;
  logic                   w_vc_ok;
  logic                   w_capture;
  logic                   w_drop;
  logic                   w_sel;
  logic                   w_xfer;
  logic                   w_push;
  logic                   w_send;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [0:PACKET_SIZE-1] w_head;

  assign w_ro      = ~r_vc_full[r_pol];
  assign w_vc_ok   = (net_do[VC_BIT] == r_pol);
  assign w_capture = net_so & w_ro & w_vc_ok;
  assign w_drop    = net_so & ~(w_ro & w_vc_ok);

  // The current-phase VC has drain priority; the other VC goes when it is empty.
  assign w_sel  = r_vc_full[r_pol] ? r_pol : ~r_pol;
  assign w_xfer = (|r_vc_full) & fab_tx_ready;

  assign w_push = fab_rx_valid & ~w_fifo_full;
  assign w_send = net_ri & ~w_fifo_empty & ~r_si;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol       <= 1'b0;
      r_vc_full   <= 2'b00;
      r_proto_err <= 1'b0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_si        <= 1'b0;
      r_di        <= '0;
    end else begin
      r_pol <= ~r_pol;
      if (w_xfer) r_vc_full[w_sel] <= 1'b0;
      if (w_capture) begin
        r_vc_full[r_pol] <= 1'b1;
        r_rx_cnt         <= r_rx_cnt + CNT_ONE;
      end
      if (w_drop) r_proto_err <= 1'b1;
      r_si <= w_send;
      if (w_send) begin
        r_di     <= w_head;
        r_tx_cnt <= r_tx_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_vc_reg[r_pol] <= net_do;
  end

  cardinal_sync_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_egress_fifo (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (fab_rx_data),
    .i_pop       (w_send),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (w_head)
  );

  assign net_polarity = r_pol;
  assign net_ro       = w_ro;
  assign net_si       = r_si;
  assign net_di       = r_di;
  assign fab_tx_valid = |r_vc_full;
  assign fab_tx_data  = (|r_vc_full) ? r_vc_reg[w_sel] : '0;
  assign fab_rx_ready = ~w_fifo_full;
  assign proto_err    = r_proto_err;
  assign rx_cnt       = r_rx_cnt;
  assign tx_cnt       = r_tx_cnt;
endmodule

// File: tb/tb_cardinal_pe_port.sv
// Directed bench for cardinal_pe_port: reset, ingress capture/drain, protocol error,
// egress pacing and back-pressure, then a long mixed-traffic run.
module tb_cardinal_pe_port;
  import cardinal_pkg::*;

  localparam int N     = 10000;
  localparam int LIMIT = 60000;

  logic        clk;
  logic        reset;
  logic        net_polarity;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        fab_tx_valid;
  logic        fab_tx_ready;
  logic [0:63] fab_tx_data;
  logic        fab_rx_valid;
  logic        fab_rx_ready;
  logic [0:63] fab_rx_data;
  logic        proto_err;
  logic [15:0] rx_cnt;
  logic [15:0] tx_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cardinal_pe_port dut (
    .clk          (clk),
    .reset        (reset),
    .net_polarity (net_polarity),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .fab_tx_valid (fab_tx_valid),
    .fab_tx_ready (fab_tx_ready),
    .fab_tx_data  (fab_tx_data),
    .fab_rx_valid (fab_rx_valid),
    .fab_rx_ready (fab_rx_ready),
    .fab_rx_data  (fab_rx_data),
    .proto_err    (proto_err),
    .rx_cnt       (rx_cnt),
    .tx_cnt       (tx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:63] mk(input logic vc, input logic [31:0] pay);
    logic [0:63] p;
    p = '0;
    p[0] = vc;
    p[32:63] = pay;
    return p;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pol(input logic v);
    @(posedge clk); #1;
    if (net_polarity !== v) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [0:9]  si_exp;
    logic [0:63] q_vc0[$];
    logic [0:63] q_vc1[$];
    logic [0:63] q_nic[$];
    int idx;
    int ki;
    int ke;
    int guard;

    reset = 1'b1;
    net_so = 1'b0;
    net_do = '0;
    net_ri = 1'b0;
    fab_tx_ready = 1'b0;
    fab_rx_valid = 1'b0;
    fab_rx_data = '0;

    // 1: reset, then idle polarity toggling
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("t1_ro", net_ro, 1'b1);
    chk1("t1_si", net_si, 1'b0);
    chk1("t1_txv", fab_tx_valid, 1'b0);
    chk1("t1_rxrdy", fab_rx_ready, 1'b1);
    chk1("t1_err", proto_err, 1'b0);
    chkw("t1_rxcnt", 64'(rx_cnt), 64'd0);
    chkw("t1_txcnt", 64'(tx_cnt), 64'd0);
    chkw("t1_di", 64'(net_di), 64'd0);
    chkw("t1_txdata", 64'(fab_tx_data), 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk1("t1_pol", net_polarity, 1'(i % 2));
    end

    // 2: VC0 packet at p=0 held while fabric stalls, then drained
    wait_pol(1'b0);
    net_do = mk(1'b0, 32'h5);
    net_so = 1'b1;
    @(negedge clk);
    chk1("t2_ro_pre", net_ro, 1'b1);
    @(posedge clk); #1;
    net_so = 1'b0;
    @(negedge clk);
    chk1("t2_txv", fab_tx_valid, 1'b1);
    chkw("t2_txdata", 64'(fab_tx_data), 64'h5);
    chk1("t2_ro_p1", net_ro, 1'b1);
    chkw("t2_rxcnt", 64'(rx_cnt), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("t2_pol0", net_polarity, 1'b0);
    chk1("t2_ro_p0", net_ro, 1'b0);
    @(posedge clk); #1;
    fab_tx_ready = 1'b1;
    @(negedge clk);
    chk1("t2_txv_xfer", fab_tx_valid, 1'b1);
    @(posedge clk); #1;
    fab_tx_ready = 1'b0;
    @(negedge clk);
    chk1("t2_drained", fab_tx_valid, 1'b0);
    chk1("t2_ro_after", net_ro, 1'b1);
    chk1("t2_err", proto_err, 1'b0);

    // 3: VC1 packet offered at p=0 is dropped and the error sticks
    wait_pol(1'b0);
    net_do = mk(1'b1, 32'hBAD);
    net_so = 1'b1;
    @(posedge clk); #1;
    net_so = 1'b0;
    @(negedge clk);
    chk1("t3_err", proto_err, 1'b1);
    chkw("t3_rxcnt", 64'(rx_cnt), 64'd1);
    chk1("t3_txv", fab_tx_valid, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("t3_err_sticky", proto_err, 1'b1);

    // 4: four pushes with the NIC always ready; sends are spaced by an idle cycle
    @(posedge clk); #1;
    net_ri = 1'b1;
    si_exp = 10'b0010101010;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      fab_rx_valid = (i < 4);
      fab_rx_data  = mk(1'(i % 2), 32'(i));
      @(negedge clk);
      chk1("t4_si", net_si, si_exp[i]);
      if (net_si) begin
        chkw("t4_di", 64'(payload_of(net_di)), 64'(idx));
        idx++;
      end
      @(posedge clk); #1;
    end
    fab_rx_valid = 1'b0;
    chkw("t4_txcnt", 64'(tx_cnt), 64'd4);
    chk1("t4_rxrdy", fab_rx_ready, 1'b1);

    // 5: fill the FIFO with the NIC busy, fifth push waits for the first send
    net_ri = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fab_rx_valid = 1'b1;
      fab_rx_data  = mk(1'b0, 32'(10 + i));
      @(posedge clk); #1;
    end
    fab_rx_data = mk(1'b0, 32'd14);
    @(negedge clk);
    chk1("t5_full", fab_rx_ready, 1'b0);
    @(posedge clk); #1;
    net_ri = 1'b1;
    @(negedge clk);
    chk1("t5_full_ri", fab_rx_ready, 1'b0);
    chk1("t5_si_pre", net_si, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("t5_si_first", net_si, 1'b1);
    chkw("t5_di_first", 64'(payload_of(net_di)), 64'd10);
    chk1("t5_rxrdy", fab_rx_ready, 1'b1);
    @(posedge clk); #1;
    fab_rx_valid = 1'b0;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (net_si) begin
        chkw("t5_di", 64'(payload_of(net_di)), 64'(11 + idx));
        idx++;
      end
      @(posedge clk); #1;
    end
    chkw("t5_sends", 64'(idx), 64'd4);
    chkw("t5_txcnt", 64'(tx_cnt), 64'd9);

    // 6: reset, then long traffic in both directions
    reset = 1'b1;
    net_ri = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("t6_err_clr", proto_err, 1'b0);
    chkw("t6_rxcnt_clr", 64'(rx_cnt), 64'd0);
    chkw("t6_txcnt_clr", 64'(tx_cnt), 64'd0);
    @(posedge clk); #1;
    ki = 0;
    ke = 0;
    guard = 0;
    while ((q_vc0.size() + q_vc1.size() < N || q_nic.size() < N) && guard < LIMIT) begin
      net_so       = (ki < N) && net_ro && (net_polarity == ki[0]);
      net_do       = mk(ki[0], 32'(ki));
      fab_rx_valid = (ke < N);
      fab_rx_data  = mk(ke[0], 32'h4000_0000 | 32'(ke));
      fab_tx_ready = 1'($urandom_range(0, 1));
      net_ri       = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (net_so) ki++;
      if (fab_rx_valid && fab_rx_ready) ke++;
      if (fab_tx_valid && fab_tx_ready) begin
        if (fab_tx_data[0]) q_vc1.push_back(fab_tx_data);
        else                q_vc0.push_back(fab_tx_data);
      end
      if (net_si) q_nic.push_back(net_di);
      @(posedge clk); #1;
      guard++;
    end
    net_so = 1'b0;
    fab_rx_valid = 1'b0;
    fab_tx_ready = 1'b0;
    chk1("t6_timeout", guard < LIMIT, 1'b1);
    chkw("t6_n_vc0", 64'(q_vc0.size()), 64'(N / 2));
    chkw("t6_n_vc1", 64'(q_vc1.size()), 64'(N / 2));
    chkw("t6_n_nic", 64'(q_nic.size()), 64'(N));
    chkw("t6_rxcnt", 64'(rx_cnt), 64'(N));
    chkw("t6_txcnt", 64'(tx_cnt), 64'(N));
    chk1("t6_err", proto_err, 1'b0);
    // Drain priority follows polarity, so order is guaranteed within each VC.
    foreach (q_vc0[j]) chkw("t6_fab_vc0", 64'(q_vc0[j]), 64'(mk(1'b0, 32'(2 * j))));
    foreach (q_vc1[j]) chkw("t6_fab_vc1", 64'(q_vc1[j]), 64'(mk(1'b1, 32'(2 * j + 1))));
    foreach (q_nic[j]) chkw("t6_nic", 64'(q_nic[j]), 64'(mk(1'(j % 2), 32'h4000_0000 | 32'(j))));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
